// File: rtl/scope_capture_ctl.sv
`default_nettype none
// ============================================================================
// Module   : scope_capture_ctl
// Purpose  : Capture sequencer for the oscilloscope sample buffer.
//            IDLE -> PRE (pretrigger fill) -> WAIT (trigger search) ->
//            POST (posttrigger fill) -> DONE. Drives the write strobe and the
//            wrapping write address of a 2^AW-deep circular ADC buffer and
//            reports the address holding the trigger sample.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            ADC-domain clock
//   reset          asynchronous, active-high reset
//   i_arm          start-capture pulse (ignored while a capture is running)
//   i_abort        cancel-capture pulse (wins over i_arm)
//   i_sample_en    one ADC sample is presented this cycle
//   i_trig_in      trigger source
//   i_trig_edge    1: rising-edge trigger, 0: level-high trigger
//   i_auto_en      enable forced trigger after timeout
//   i_auto_timeout WAIT-state samples before forced trigger
//   i_pretrig      samples kept before the trigger sample (0..N-1)
//   o_wr_en        buffer write strobe (registered)
//   o_wr_addr      buffer write address, valid with o_wr_en
//   o_trig_addr    address holding the trigger sample
//   o_trig_forced  last trigger came from the auto timeout
//   o_done         record complete, buffer stable
//   o_state        IDLE=0 PRE=1 WAIT=2 POST=3 DONE=4
// ============================================================================
module scope_capture_ctl #(
  parameter int AW     = 13,
  parameter int AUTO_W = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_arm,
  input  logic              i_abort,
  input  logic              i_sample_en,
  input  logic              i_trig_in,
  input  logic              i_trig_edge,
  input  logic              i_auto_en,
  input  logic [AUTO_W-1:0] i_auto_timeout,
  input  logic [AW-1:0]     i_pretrig,
  output logic              o_wr_en,
  output logic [AW-1:0]     o_wr_addr,
  output logic [AW-1:0]     o_trig_addr,
  output logic              o_trig_forced,
  output logic              o_done,
  output logic [2:0]        o_state
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [AW-1:0]     c_one      = AW'(1);
  localparam logic [AUTO_W-1:0] c_auto_one = AUTO_W'(1);

  // Registered state
  state_t              r_state;
  logic [AW-1:0]       r_ptr;         // next buffer address to write
  logic [AW-1:0]       r_cnt;         // remaining PRE or POST samples
  logic [AUTO_W-1:0]   r_auto_cnt;    // samples seen in WAIT
  logic                r_trig_prev;   // trig_in of the previous sample
  logic                r_wr_en;
  logic [AW-1:0]       r_wr_addr;
  logic [AW-1:0]       r_trig_addr;
  logic                r_trig_forced;
  logic                r_done;
  // Configuration captured at arm, held for the whole record
  logic [AW-1:0]       r_pretrig;
  logic                r_edge;
  logic                r_auto_en;
  logic [AUTO_W-1:0]   r_auto_to;

  // Next-state values
  state_t              w_state_nxt;
  logic [AW-1:0]       w_ptr_nxt;
  logic [AW-1:0]       w_cnt_nxt;
  logic [AUTO_W-1:0]   w_auto_nxt;
  logic                w_prev_nxt;
  logic                w_wr_en_nxt;
  logic [AW-1:0]       w_wr_addr_nxt;
  logic [AW-1:0]       w_trig_addr_nxt;
  logic                w_forced_nxt;
  logic                w_done_nxt;
  logic [AW-1:0]       w_pretrig_nxt;
  logic                w_edge_nxt;
  logic                w_auto_en_nxt;
  logic [AUTO_W-1:0]   w_auto_to_nxt;

  logic                w_active;
  logic                w_event;
  logic                w_auto_fire;
  logic [AW-1:0]       w_post_len;

  assign w_active    = (r_state == ST_PRE) || (r_state == ST_WAIT) || (r_state == ST_POST);
  // In edge mode a sample qualifies only if the previous sample was low.
  assign w_event     = i_sample_en & i_trig_in & (~r_edge | ~r_trig_prev);
  assign w_auto_fire = r_auto_en & (r_auto_cnt == r_auto_to);
  // N-1-pretrig in AW bits is simply the bitwise complement of pretrig.
  assign w_post_len  = ~r_pretrig;
  assign w_prev_nxt  = i_sample_en ? i_trig_in : r_trig_prev;
  assign w_done_nxt  = (w_state_nxt == ST_DONE);

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_cnt_nxt       = r_cnt;
    w_auto_nxt      = r_auto_cnt;
    w_wr_en_nxt     = 1'b0;
    w_wr_addr_nxt   = r_wr_addr;
    w_trig_addr_nxt = r_trig_addr;
    w_forced_nxt    = r_trig_forced;
    w_pretrig_nxt   = r_pretrig;
    w_edge_nxt      = r_edge;
    w_auto_en_nxt   = r_auto_en;
    w_auto_to_nxt   = r_auto_to;

    if (i_abort) begin
      // Abort freezes everything else and drops any write from this cycle.
      w_state_nxt = ST_IDLE;
    end else begin
      if (w_active && i_sample_en) begin
        w_wr_en_nxt   = 1'b1;
        w_wr_addr_nxt = r_ptr;
        w_ptr_nxt     = r_ptr + c_one;
      end

      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_arm) begin
            w_ptr_nxt     = '0;
            w_cnt_nxt     = i_pretrig;
            w_auto_nxt    = '0;
            w_forced_nxt  = 1'b0;
            w_pretrig_nxt = i_pretrig;
            w_edge_nxt    = i_trig_edge;
            w_auto_en_nxt = i_auto_en;
            w_auto_to_nxt = i_auto_timeout;
            w_state_nxt   = (i_pretrig == '0) ? ST_WAIT : ST_PRE;
          end
        end
        ST_PRE: begin
          if (i_sample_en) begin
            w_cnt_nxt = r_cnt - c_one;
            if (r_cnt == c_one) begin
              w_state_nxt = ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (i_sample_en) begin
            if (w_event || w_auto_fire) begin
              w_trig_addr_nxt = r_ptr;
              w_forced_nxt    = ~w_event;
              w_cnt_nxt       = w_post_len;
              w_state_nxt     = (w_post_len == '0) ? ST_DONE : ST_POST;
            end else if (r_auto_en) begin
              // Only counts while auto is enabled, so it stops at the timeout.
              w_auto_nxt = r_auto_cnt + c_auto_one;
            end
          end
        end
        ST_POST: begin
          if (i_sample_en) begin
            w_cnt_nxt = r_cnt - c_one;
            if (r_cnt == c_one) begin
              w_state_nxt = ST_DONE;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_ptr         <= '0;
      r_cnt         <= '0;
      r_auto_cnt    <= '0;
      r_trig_prev   <= 1'b0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= '0;
      r_trig_addr   <= '0;
      r_trig_forced <= 1'b0;
      r_done        <= 1'b0;
      r_pretrig     <= '0;
      r_edge        <= 1'b0;
      r_auto_en     <= 1'b0;
      r_auto_to     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_ptr         <= w_ptr_nxt;
      r_cnt         <= w_cnt_nxt;
      r_auto_cnt    <= w_auto_nxt;
      r_trig_prev   <= w_prev_nxt;
      r_wr_en       <= w_wr_en_nxt;
      r_wr_addr     <= w_wr_addr_nxt;
      r_trig_addr   <= w_trig_addr_nxt;
      r_trig_forced <= w_forced_nxt;
      r_done        <= w_done_nxt;
      r_pretrig     <= w_pretrig_nxt;
      r_edge        <= w_edge_nxt;
      r_auto_en     <= w_auto_en_nxt;
      r_auto_to     <= w_auto_to_nxt;
    end
  end

  assign o_wr_en       = r_wr_en;
  assign o_wr_addr     = r_wr_addr;
  assign o_trig_addr   = r_trig_addr;
  assign o_trig_forced = r_trig_forced;
  assign o_done        = r_done;
  assign o_state       = r_state;

endmodule
`default_nettype wire

// File: tb/tb_scope_capture_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_scope_capture_ctl
// Purpose  : Self-checking bench for scope_capture_ctl (AW=4, N=16) with a
//            sample-level reference model of the capture record.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scope_capture_ctl;

  localparam int AW     = 4;
  localparam int AUTO_W = 8;
  localparam int N      = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              arm, abort_i, se, trig, edge_i, auto_en;
  logic [AUTO_W-1:0] auto_to;
  logic [AW-1:0]     pre;
  logic              wr_en;
  logic [AW-1:0]     wr_addr, trig_addr;
  logic              trig_forced, done;
  logic [2:0]        state;

  scope_capture_ctl #(.AW(AW), .AUTO_W(AUTO_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_arm          (arm),
    .i_abort        (abort_i),
    .i_sample_en    (se),
    .i_trig_in      (trig),
    .i_trig_edge    (edge_i),
    .i_auto_en      (auto_en),
    .i_auto_timeout (auto_to),
    .i_pretrig      (pre),
    .o_wr_en        (wr_en),
    .o_wr_addr      (wr_addr),
    .o_trig_addr    (trig_addr),
    .o_trig_forced  (trig_forced),
    .o_done         (done),
    .o_state        (state)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int nerr = 0;
  int writes = 0;

  // Reference model: phase of the record plus sample counts since arm.
  int m_state, m_ptr, m_written_pre, m_wait_samples, m_post_written;
  int m_trig_addr, m_wr_addr, c_pre, c_to;
  bit m_forced, m_prev, m_wr_en, c_edge, c_auto;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_ptr = 0; m_written_pre = 0; m_wait_samples = 0;
    m_post_written = 0; m_trig_addr = 0; m_wr_addr = 0; m_forced = 0;
    m_prev = 0; m_wr_en = 0; c_pre = 0; c_to = 0; c_edge = 0; c_auto = 0;
  endtask

  task automatic model_step();
    bit ev;
    if (reset) begin
      model_reset();
      return;
    end
    ev = se && trig && (!c_edge || !m_prev);
    if (se) m_prev = trig;
    m_wr_en = 0;
    if (abort_i) begin
      m_state = 0;
      return;
    end
    if (m_state == 0 || m_state == 4) begin
      if (arm) begin
        m_ptr = 0; m_written_pre = 0; m_wait_samples = 0; m_post_written = 0;
        m_forced = 0;
        c_pre = int'(pre); c_edge = edge_i; c_auto = auto_en; c_to = int'(auto_to);
        m_state = (c_pre == 0) ? 2 : 1;
      end
    end else if (se) begin
      int addr;
      addr = m_ptr;
      m_wr_en = 1; m_wr_addr = addr; m_ptr = (m_ptr + 1) % N;
      if (m_state == 1) begin
        m_written_pre++;
        if (m_written_pre == c_pre) m_state = 2;
      end else if (m_state == 2) begin
        if (ev || (c_auto && m_wait_samples == c_to)) begin
          m_trig_addr = addr;
          m_forced = !ev;
          m_state = (N - 1 - c_pre == 0) ? 4 : 3;
        end else begin
          m_wait_samples++;
        end
      end else begin
        m_post_written++;
        if (m_post_written == N - 1 - c_pre) m_state = 4;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    if (wr_en === 1'b1) writes++;
    chk("state", 32'(state), 32'(m_state));
    chk("wr_en", 32'(wr_en), 32'(m_wr_en));
    chk("done", 32'(done), 32'(m_state == 4));
    if (m_wr_en || m_state == 4) chk("wr_addr", 32'(wr_addr), 32'(m_wr_addr));
    if (m_state == 4) begin
      chk("trig_addr", 32'(trig_addr), 32'(m_trig_addr));
      chk("trig_forced", 32'(trig_forced), 32'(m_forced));
    end
  endtask

  task automatic do_arm(input int p, input bit e, input bit ae, input int to, input bit t);
    pre = AW'(p); edge_i = e; auto_en = ae; auto_to = AUTO_W'(to); trig = t;
    arm = 1; se = 1;
    tick();
    arm = 0;
    writes = 0;
  endtask

  initial begin
    int ns, cyc;
    reset = 1; arm = 0; abort_i = 0; se = 0; trig = 0; edge_i = 0;
    auto_en = 0; auto_to = '0; pre = '0;
    model_reset();
    #12;
    chk("rst_state", 32'(state), 0);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_trig_addr", 32'(trig_addr), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_forced", 32'(trig_forced), 0);
    @(posedge clk); #1;
    reset = 0;

    // 1: pretrig 4, edge trigger on the 8th sample
    do_arm(4, 1, 0, 0, 0);
    ns = 0;
    for (cyc = 0; cyc < 60 && m_state != 4; cyc++) begin
      se = 1; trig = (ns >= 7);
      tick();
      ns++;
    end
    chk("s1_done_state", 32'(state), 4);
    chk("s1_trig_addr", 32'(trig_addr), 7);
    chk("s1_last_addr", 32'(wr_addr), 2);
    chk("s1_writes", 32'(writes), 19);

    // 2: pretrig 0, level trigger already high (arm from DONE)
    do_arm(0, 0, 0, 0, 1);
    chk("s2_skip_pre", 32'(state), 2);
    for (cyc = 0; cyc < 60 && m_state != 4; cyc++) begin
      se = 1; trig = 1;
      tick();
    end
    chk("s2_trig_addr", 32'(trig_addr), 0);
    chk("s2_writes", 32'(writes), 16);
    chk("s2_forced", 32'(trig_forced), 0);

    // 3: auto timeout 5 after 2 pretrigger samples
    do_arm(2, 0, 1, 5, 0);
    for (cyc = 0; cyc < 60 && m_state != 4; cyc++) begin
      se = 1; trig = 0;
      tick();
    end
    chk("s3_trig_addr", 32'(trig_addr), 7);
    chk("s3_forced", 32'(trig_forced), 1);
    chk("s3_writes", 32'(writes), 21);

    // 4: sparse samples, trigger high before WAIT must fall and rise again
    abort_i = 1; se = 1; trig = 1; tick(); abort_i = 0;
    do_arm(3, 1, 0, 0, 1);
    for (cyc = 0; cyc < 300 && m_state != 4; cyc++) begin
      se = (cyc % 3 == 0);
      trig = !(cyc >= 30 && cyc < 40);
      tick();
    end
    chk("s4_done_state", 32'(state), 4);
    chk("s4_trig_addr_late", 32'(trig_addr >= 4'd4 || trig_addr < 4'd3), 1);

    // 5: abort during POST, then re-arm restarts at address 0
    do_arm(1, 0, 0, 0, 1);
    for (cyc = 0; cyc < 40 && !(m_state == 3 && m_post_written >= 3); cyc++) begin
      se = 1; trig = 1;
      tick();
    end
    abort_i = 1; se = 1;
    tick();
    abort_i = 0;
    chk("s5_abort_state", 32'(state), 0);
    chk("s5_abort_wr_en", 32'(wr_en), 0);
    chk("s5_abort_done", 32'(done), 0);
    do_arm(1, 0, 0, 0, 0);
    se = 1; tick();
    chk("s5_rearm_wr_en", 32'(wr_en), 1);
    chk("s5_rearm_addr", 32'(wr_addr), 0);
    abort_i = 1; tick(); abort_i = 0;

    // 6: arm+abort together stays IDLE; arm during WAIT ignored
    arm = 1; abort_i = 1; se = 1;
    tick();
    arm = 0; abort_i = 0;
    chk("s6_arm_abort", 32'(state), 0);
    do_arm(0, 1, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      se = 1; trig = 0; arm = (i == 5);
      tick();
    end
    arm = 0;
    chk("s6_wait_ptr", 32'(wr_addr), 11);
    abort_i = 1; tick(); abort_i = 0;

    // 7: reset asserted mid-capture
    do_arm(5, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin se = 1; tick(); end
    #2 reset = 1;
    #1;
    chk("s7_async_state", 32'(state), 0);
    chk("s7_async_wr_en", 32'(wr_en), 0);
    chk("s7_async_addr", 32'(wr_addr), 0);
    tick();
    reset = 0;
    tick();

    // 8: randomized records
    for (int r = 0; r < 8; r++) begin
      do_arm($urandom_range(0, N - 1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 20), 1'($urandom_range(0, 1)));
      for (cyc = 0; cyc < 400 && m_state != 4 && m_state != 0; cyc++) begin
        se = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 5) == 0) trig = ~trig;
        abort_i = ($urandom_range(0, 149) == 0);
        arm = ($urandom_range(0, 19) == 0);
        tick();
      end
      abort_i = 0; arm = 0;
      chk("s8_record_end", 32'(m_state == 4 || m_state == 0), 1);
      for (int i = 0; i < 3; i++) begin se = 1; tick(); end
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
`default_nettype wire
